// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   ALU operand selector plus ID/EX pipeline register for the pipelined MIPS
//   core. Operand A comes from rs data or a forwarded value. Operand B comes
//   from rt data, a forwarded value or the extended immediate. Both operands
//   and the forwarded rt value (store datum) are registered into EX. The block
//   supports stall, flush and a valid bit. It also counts consecutive stall
//   cycles, saturating at 255.
//
//   Optional feature: ALU_OPND_FWD_EN. When it is defined, fwd_sel_a and
//   fwd_sel_b pick forwarding slots. When it is undefined, the selects and
//   fwd_data are ignored and the operands come only from read1, read2 and
//   ext_imm.
//
// Parameters
//   WIDTH        datapath width
//   NFWD         number of forwarding slots (1..3)
// Ports
//   clk, reset   rising-edge clock, async active-high reset
//   in_valid     ID holds a real instruction
//   stall        hold EX register contents
//   flush        insert a bubble into EX (wins over stall)
//   alu_src      0: B from rt path, 1: B = ext_imm
//   fwd_sel_a/b  0: register value, k: forwarding slot k-1
//   read1/read2  rs / rt register data
//   ext_imm      extended immediate
//   fwd_data     forwarding slots, slot k at [k*WIDTH +: WIDTH]
//   src_a/src_b  registered ALU operands
//   rt_fwd       registered rt value (store data), independent of alu_src
//   out_valid    EX holds a real instruction
//   stall_cycles consecutive stall edges, saturating at 255

module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int NFWD  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  alu_src,
  input  logic [1:0]            fwd_sel_a,
  input  logic [1:0]            fwd_sel_b,
  input  logic [WIDTH-1:0]      read1,
  input  logic [WIDTH-1:0]      read2,
  input  logic [WIDTH-1:0]      ext_imm,
  input  logic [NFWD*WIDTH-1:0] fwd_data,
  output logic [WIDTH-1:0]      src_a,
  output logic [WIDTH-1:0]      src_b,
  output logic [WIDTH-1:0]      rt_fwd,
  output logic                  out_valid,
  output logic [7:0]            stall_cycles
);

  localparam int STAGES = 1;

  logic [WIDTH-1:0] a_next, rt_next, b_next;
  logic [STAGES:0]  vld_pipe;

`ifdef ALU_OPND_FWD_EN
  // A selector that names no existing slot (e.g. 3 with NFWD=2) falls back
  // to the register value, so the mux output is never undefined.
  function automatic logic [WIDTH-1:0] pick(
    input logic [1:0]            sel,
    input logic [WIDTH-1:0]      reg_val,
    input logic [NFWD*WIDTH-1:0] fwd
  );
    logic [WIDTH-1:0] r;
    r = reg_val;
    for (int k = 0; k < NFWD; k++)
      if (sel == 2'(k + 1)) r = fwd[k*WIDTH +: WIDTH];
    return r;
  endfunction

  assign a_next  = pick(fwd_sel_a, read1, fwd_data);
  assign rt_next = pick(fwd_sel_b, read2, fwd_data);
`else
  // Forwarding is compiled out. The selects and slots are kept on the port
  // list so that the same top level fits both builds.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_sel_a, fwd_sel_b, fwd_data};
  assign a_next  = read1;
  assign rt_next = read2;
`endif

  assign b_next = alu_src ? ext_imm : rt_next;

  // vld_pipe[0] is the ID-side valid. vld_pipe[STAGES] is the EX-side valid.
  assign vld_pipe[0] = in_valid;
  assign out_valid   = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_a              <= '0;
      src_b              <= '0;
      rt_fwd             <= '0;
      vld_pipe[STAGES:1] <= '0;
    end else if (flush) begin
      src_a              <= '0;
      src_b              <= '0;
      rt_fwd             <= '0;
      vld_pipe[STAGES:1] <= '0;
    end else if (!stall) begin
      // A bubble loads zero data, so that EX never carries stale operands.
      src_a              <= in_valid ? a_next  : '0;
      src_b              <= in_valid ? b_next  : '0;
      rt_fwd             <= in_valid ? rt_next : '0;
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end
  end

  // Counts the edges of the current stall run. A flush ends the run even if
  // stall stays high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall && !flush)
      stall_cycles <= (stall_cycles == 8'hFF) ? 8'hFF : stall_cycles + 8'd1;
    else
      stall_cycles <= '0;
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;
  localparam int WIDTH = 32;
  localparam int NFWD  = 2;

  logic clk = 0, reset = 1;
  logic in_valid = 0, stall = 0, flush = 0, alu_src = 0;
  logic [1:0] fwd_sel_a = 0, fwd_sel_b = 0;
  logic [WIDTH-1:0] read1 = 0, read2 = 0, ext_imm = 0;
  logic [NFWD*WIDTH-1:0] fwd_data = 0;
  logic [WIDTH-1:0] src_a, src_b, rt_fwd;
  logic out_valid;
  logic [7:0] stall_cycles;

  int checks = 0, errors = 0;

  alu_operand_stage #(.WIDTH(WIDTH), .NFWD(NFWD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
    .flush(flush), .alu_src(alu_src), .fwd_sel_a(fwd_sel_a),
    .fwd_sel_b(fwd_sel_b), .read1(read1), .read2(read2), .ext_imm(ext_imm),
    .fwd_data(fwd_data), .src_a(src_a), .src_b(src_b), .rt_fwd(rt_fwd),
    .out_valid(out_valid), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: what EX must hold, according to the stage rules.
  logic [WIDTH-1:0] m_a = 0, m_b = 0, m_rt = 0;
  logic m_v = 0;
  int m_cnt = 0;

  function automatic logic [WIDTH-1:0] model_pick(input int sel, input logic [WIDTH-1:0] regv,
                                                  input logic [NFWD*WIDTH-1:0] fd);
    logic [WIDTH-1:0] slots [NFWD];
    for (int k = 0; k < NFWD; k++) slots[k] = fd[k*WIDTH +: WIDTH];
`ifdef ALU_OPND_FWD_EN
    if (sel >= 1 && sel <= NFWD) return slots[sel-1];
`endif
    return regv;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a <= 0; m_b <= 0; m_rt <= 0; m_v <= 0; m_cnt <= 0;
    end else begin
      logic [WIDTH-1:0] a, rt;
      a  = model_pick(int'(fwd_sel_a), read1, fwd_data);
      rt = model_pick(int'(fwd_sel_b), read2, fwd_data);
      if (flush) begin
        m_a <= 0; m_b <= 0; m_rt <= 0; m_v <= 0;
      end else if (!stall) begin
        m_v  <= in_valid;
        m_a  <= in_valid ? a : 0;
        m_rt <= in_valid ? rt : 0;
        m_b  <= in_valid ? (alu_src ? ext_imm : rt) : 0;
      end
      m_cnt <= (stall && !flush) ? ((m_cnt + 1 > 255) ? 255 : m_cnt + 1) : 0;
    end
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("model_src_a", src_a, m_a);
      check("model_src_b", src_b, m_b);
      check("model_rt_fwd", rt_fwd, m_rt);
      check("model_out_valid", {31'd0, out_valid}, {31'd0, m_v});
      check("model_stall_cycles", {24'd0, stall_cycles}, m_cnt[WIDTH-1:0]);
    end
  end

  task automatic edge_step();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check("reset_out_valid", {31'd0, out_valid}, 0);
    check("reset_src_a", src_a, 0);
    check("reset_cnt", {24'd0, stall_cycles}, 0);

    // Basic load
    in_valid = 1; read1 = 32'h11; read2 = 32'h22; ext_imm = 32'hFFFF_FFF0; alu_src = 1;
    edge_step();
    check("load_src_a", src_a, 32'h11);
    check("load_src_b", src_b, 32'hFFFF_FFF0);
    check("load_rt_fwd", rt_fwd, 32'h22);
    check("load_valid", {31'd0, out_valid}, 1);

    // Forwarding
    fwd_data = {32'hBBBB, 32'hAAAA}; fwd_sel_a = 2; fwd_sel_b = 1; alu_src = 0;
    edge_step();
`ifdef ALU_OPND_FWD_EN
    check("fwd_src_a", src_a, 32'hBBBB);
    check("fwd_src_b", src_b, 32'hAAAA);
    check("fwd_rt_fwd", rt_fwd, 32'hAAAA);
`else
    check("nofwd_src_a", src_a, 32'h11);
    check("nofwd_src_b", src_b, 32'h22);
`endif
    fwd_sel_b = 3;
    edge_step();
    check("sel3_src_b", src_b, 32'h22);
    fwd_sel_a = 0; fwd_sel_b = 0;

    // Stall hold and count
    read1 = 5; read2 = 5; edge_step();
    check("stall_pre_a", src_a, 5);
    stall = 1;
    for (int i = 1; i <= 3; i++) begin
      read1 = $urandom; read2 = $urandom; ext_imm = $urandom; alu_src = 1;
      edge_step();
      check("stall_hold_a", src_a, 5);
      check("stall_hold_b", src_b, 5);
      check("stall_cnt", {24'd0, stall_cycles}, i);
    end
    stall = 0; read1 = 32'h77; alu_src = 0; read2 = 32'h66;
    edge_step();
    check("release_a", src_a, 32'h77);
    check("release_cnt", {24'd0, stall_cycles}, 0);

    // Flush beats stall
    stall = 1; edge_step();
    stall = 1; flush = 1; edge_step();
    check("flush_valid", {31'd0, out_valid}, 0);
    check("flush_a", src_a, 0);
    check("flush_rt", rt_fwd, 0);
    check("flush_cnt", {24'd0, stall_cycles}, 0);
    flush = 0; stall = 0;

    // Saturation
    edge_step();
    stall = 1;
    for (int i = 1; i <= 300; i++) begin
      edge_step();
      if (i == 254) check("sat_254", {24'd0, stall_cycles}, 254);
      if (i == 255) check("sat_255", {24'd0, stall_cycles}, 255);
    end
    check("sat_300", {24'd0, stall_cycles}, 255);

    // Reset mid-stall with loaded outputs
    stall = 0; read1 = 32'h99; edge_step();
    stall = 1; edge_step(); edge_step();
    #1 reset = 1; #1;
    check("rst_async_a", src_a, 0);
    check("rst_async_valid", {31'd0, out_valid}, 0);
    check("rst_async_cnt", {24'd0, stall_cycles}, 0);
    @(negedge clk); reset = 0;
    edge_step();
    check("rst_first_stall", {24'd0, stall_cycles}, 1);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) stall = ~stall;
      flush     = ($urandom_range(0, 15) == 0);
      alu_src   = $urandom_range(0, 1);
      fwd_sel_a = 2'($urandom_range(0, 3));
      fwd_sel_b = 2'($urandom_range(0, 3));
      read1 = $urandom; read2 = $urandom; ext_imm = $urandom;
      fwd_data = {$urandom, $urandom};
      edge_step();
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Parametrised ALU operand selector and ID/EX pipeline register for the pipelined MIPS core. Generalises the single-cycle ALU-source mux: picks operand A from rs data or a forwarded value, operand B from rt data, a forwarded value or the extended immediate, and registers both (plus the store datum) into the EX stage. Supports stall, flush and a valid bit, and reports how long the current stall has lasted.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits.
- NFWD, 2, number of forwarding sources (legal 1..3).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  ID stage holds a real instruction.
- stall  input  1  hold EX register contents.
- flush  input  1  insert a bubble into EX.
- alu_src  input  1  0 = operand B from rt path; 1 = ext_imm.
- fwd_sel_a  input  2  0 = read1; k (1..NFWD) = forwarding slot k-1.
- fwd_sel_b  input  2  0 = read2; k (1..NFWD) = forwarding slot k-1.
- read1  input  WIDTH  rs register data.
- read2  input  WIDTH  rt register data.
- ext_imm  input  WIDTH  extended 16-bit immediate.
- fwd_data  input  NFWD*WIDTH  forwarding values; slot k at bits [k*WIDTH +: WIDTH].
- src_a  output  WIDTH  registered ALU operand A.
- src_b  output  WIDTH  registered ALU operand B.
- rt_fwd  output  WIDTH  registered forwarded rt value (store data), independent of alu_src.
- out_valid  output  1  EX stage holds a real instruction.
- stall_cycles  output  8  consecutive stall cycles, saturating.

## Operation
- Combinational select: a_next = fwd_sel_a ? slot : read1; rt_next = fwd_sel_b ? slot : read2; b_next = alu_src ? ext_imm : rt_next.
- Selector value > NFWD selects the register value (0 behaviour); never X.
- Register update each rising edge, priority reset > flush > stall > load:
  - flush: src_a, src_b, rt_fwd = 0; out_valid = 0.
  - stall (no flush): all data outputs and out_valid hold.
  - load, in_valid=1: outputs take a_next, b_next, rt_next; out_valid = 1.
  - load, in_valid=0: data outputs = 0; out_valid = 0.
- stall_cycles: increments on each edge with stall=1 and flush=0, saturating at 255; cleared to 0 on any edge with stall=0 or flush=1.
- No state machine beyond the pipeline register and counter; no arithmetic on data.

## Timing
- Reset (asynchronous, immediate): src_a = src_b = rt_fwd = 0, out_valid = 0, stall_cycles = 0.
- Latency one cycle: inputs sampled at edge N appear on outputs after edge N.
- Inputs need to be valid only around the sampling edge. Inputs are ignored while stalled.
- stall and flush asserted together: flush wins; the counter clears.
- Reset asserted mid-stall: all outputs clear at once; the first edge after release with stall=1 gives stall_cycles = 1.
- stall_cycles saturation: at 255 it stays 255 while stall persists.

## Configuration
- ALU_OPND_FWD_EN defined: forwarding selects act as described.
- Undefined: fwd_sel_a/fwd_sel_b are ignored and treated as 0. Operands come only from read1, read2 and ext_imm. The fwd_data port remains but is unused. All register, stall, flush and counter behaviour is unchanged.

## Test plan
- Reset: assert reset mid-cycle with the outputs loaded -> all outputs 0 immediately, out_valid=0.
- Basic load, WIDTH=32: read1=0x11, read2=0x22, ext_imm=0xFFFF_FFF0, alu_src=1, in_valid=1 -> after one edge src_a=0x11, src_b=0xFFFF_FFF0, rt_fwd=0x22, out_valid=1.
- Forwarding, NFWD=2 with ALU_OPND_FWD_EN: slot0=0xAAAA, slot1=0xBBBB, fwd_sel_a=2, fwd_sel_b=1, alu_src=0 -> src_a=0xBBBB, src_b=rt_fwd=0xAAAA. fwd_sel_b=3 -> src_b=read2. Without the macro -> src_a=read1, src_b=read2.
- Stall: load 0x5, then stall=1 for 3 edges with changing inputs -> outputs hold 0x5, stall_cycles=1,2,3. Release -> new data loads and stall_cycles=0.
- Flush priority: stall=1 and flush=1 on one edge -> out_valid=0, data 0, stall_cycles=0.
- Saturation: stall held for 300 edges -> stall_cycles reaches 255 and stays at 255.
